// File: rtl/exe_stage_ctrl_if.sv
// ----------------------------------------------------------------------------
// exe_stage_ctrl_if
// Bundles every non-clock, non-reset signal of the execute-stage controller:
//   - decode -> EXE offer    : ds_to_es_valid, ds_pc, ds_alu_op, ds_src1/2,
//                              ds_rf_src1/2, ds_dest, ds_gr_we, es_allowin
//   - EXE -> shared ALU      : alu_op, alu_src1/2, alu_rf_src1/2, alu_pc
//   - shared ALU -> EXE      : alu_result, alu_br_taken, alu_br_target
//   - EXE -> MEM handoff     : es_to_ms_valid/pc/result/dest/gr_we, ms_allowin
//   - hazard/forwarding info : es_fwd_valid, es_fwd_dest, es_fwd_ready
//   - branch redirect        : br_redirect, br_target
// modport master : the execute-stage controller itself
// modport slave  : the surrounding pipeline (decode, ALU, MEM, fetch)
// ----------------------------------------------------------------------------
interface exe_stage_ctrl_if;
    // decode -> EXE
    logic        ds_to_es_valid;
    logic        es_allowin;
    logic [31:0] ds_pc;
    logic [4:0]  ds_alu_op;
    logic [31:0] ds_src1;
    logic [31:0] ds_src2;
    logic [31:0] ds_rf_src1;
    logic [31:0] ds_rf_src2;
    logic [4:0]  ds_dest;
    logic        ds_gr_we;

    // EXE <-> ALU
    logic [4:0]  alu_op;
    logic [31:0] alu_src1;
    logic [31:0] alu_src2;
    logic [31:0] alu_rf_src1;
    logic [31:0] alu_rf_src2;
    logic [31:0] alu_pc;
    logic [31:0] alu_result;
    logic        alu_br_taken;
    logic [31:0] alu_br_target;

    // EXE -> MEM
    logic        ms_allowin;
    logic        es_to_ms_valid;
    logic [31:0] es_to_ms_pc;
    logic [31:0] es_to_ms_result;
    logic [4:0]  es_to_ms_dest;
    logic        es_to_ms_gr_we;

    // forwarding / hazard
    logic        es_fwd_valid;
    logic [4:0]  es_fwd_dest;
    logic        es_fwd_ready;

    // redirect to IF/ID
    logic        br_redirect;
    logic [31:0] br_target;

    modport master (
        input  ds_to_es_valid, ds_pc, ds_alu_op, ds_src1, ds_src2,
               ds_rf_src1, ds_rf_src2, ds_dest, ds_gr_we,
               alu_result, alu_br_taken, alu_br_target, ms_allowin,
        output es_allowin, alu_op, alu_src1, alu_src2, alu_rf_src1,
               alu_rf_src2, alu_pc, es_to_ms_valid, es_to_ms_pc,
               es_to_ms_result, es_to_ms_dest, es_to_ms_gr_we,
               es_fwd_valid, es_fwd_dest, es_fwd_ready, br_redirect, br_target
    );

    modport slave (
        output ds_to_es_valid, ds_pc, ds_alu_op, ds_src1, ds_src2,
               ds_rf_src1, ds_rf_src2, ds_dest, ds_gr_we,
               alu_result, alu_br_taken, alu_br_target, ms_allowin,
        input  es_allowin, alu_op, alu_src1, alu_src2, alu_rf_src1,
               alu_rf_src2, alu_pc, es_to_ms_valid, es_to_ms_pc,
               es_to_ms_result, es_to_ms_dest, es_to_ms_gr_we,
               es_fwd_valid, es_fwd_dest, es_fwd_ready, br_redirect, br_target
    );
endinterface

// File: rtl/exe_stage_ctrl.sv
// ----------------------------------------------------------------------------
// exe_stage_ctrl
// Execute-stage controller of the single-issue pipeline. Holds the instruction
// accepted from decode, feeds the shared ALU from its stage registers, waits
// ALU_LAT cycles, then offers the result to MEM with a valid/allowin
// handshake. A taken branch raises a one-cycle redirect; any instruction
// offered by decode in that cycle is wrong-path and is swallowed.
// Ports:
//   clk    : clock, all state updates on the rising edge
//   resetn : asynchronous active-low reset
//   bus    : exe_stage_ctrl_if.master (decode offer, ALU, MEM, fwd, redirect)
// Parameter:
//   ALU_LAT : ALU cycles per instruction, 1..15
// ----------------------------------------------------------------------------
module exe_stage_ctrl #(
    parameter int ALU_LAT = 1
) (
    input  logic               clk,
    input  logic               resetn,
    exe_stage_ctrl_if.master   bus
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_EXEC  = 2'd1,
        ST_DONE  = 2'd2
    } es_state_t;

    // Counter value at which the ALU result is ready.
    localparam logic [3:0] LAT_LAST = 4'(ALU_LAT - 1);
    // Where a fresh load lands: single-cycle ALUs skip EXEC entirely.
    localparam es_state_t LOAD_STATE = (ALU_LAT == 1) ? ST_DONE : ST_EXEC;

    es_state_t   state_reg, state_next;
    logic [3:0]  lat_cnt_reg, lat_cnt_next;
    logic        br_done_reg, br_done_next;

    logic [31:0] pc_reg;
    logic [4:0]  op_reg;
    logic [31:0] src1_reg;
    logic [31:0] src2_reg;
    logic [31:0] rf_src1_reg;
    logic [31:0] rf_src2_reg;
    logic [4:0]  dest_reg;
    logic        gr_we_reg;

    logic es_valid;
    logic ready_go;
    logic es_allowin;
    logic br_redirect;
    logic load;
    logic leave;

    assign es_valid    = (state_reg != ST_EMPTY);
    assign ready_go    = (state_reg == ST_DONE);
    // br_done keeps a stalled branch from redirecting a second time.
    assign br_redirect = ready_go & bus.alu_br_taken & ~br_done_reg;
    assign es_allowin  = ~es_valid | (ready_go & bus.ms_allowin);
    // The offer in a redirect cycle is wrong-path: handshake happens, no load.
    assign load        = es_allowin & bus.ds_to_es_valid & ~br_redirect;
    assign leave       = ready_go & bus.ms_allowin;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next   = state_reg;
        lat_cnt_next = lat_cnt_reg;
        br_done_next = br_done_reg;

        case (state_reg)
            ST_EMPTY: begin
                if (load) begin
                    state_next   = LOAD_STATE;
                    lat_cnt_next = 4'd0;
                end
            end
            ST_EXEC: begin
                lat_cnt_next = lat_cnt_reg + 4'd1;
                if (lat_cnt_reg + 4'd1 >= LAT_LAST) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (leave) begin
                    if (load) begin
                        state_next   = LOAD_STATE;
                        lat_cnt_next = 4'd0;
                    end else begin
                        state_next = ST_EMPTY;
                    end
                end
            end
            default: begin
                state_next   = ST_EMPTY;
                lat_cnt_next = 4'd0;
            end
        endcase

        if (load) begin
            br_done_next = 1'b0;
        end else if (br_redirect) begin
            br_done_next = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Control state
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg   <= ST_EMPTY;
            lat_cnt_reg <= 4'd0;
            br_done_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            lat_cnt_reg <= lat_cnt_next;
            br_done_reg <= br_done_next;
        end
    end

    // ------------------------------------------------------------------
    // Stage registers: capture only on an accepted load, hold otherwise so
    // the ALU inputs stay stable across stalls.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pc_reg      <= 32'd0;
            op_reg      <= 5'd0;
            src1_reg    <= 32'd0;
            src2_reg    <= 32'd0;
            rf_src1_reg <= 32'd0;
            rf_src2_reg <= 32'd0;
            dest_reg    <= 5'd0;
            gr_we_reg   <= 1'b0;
        end else if (load) begin
            pc_reg      <= bus.ds_pc;
            op_reg      <= bus.ds_alu_op;
            src1_reg    <= bus.ds_src1;
            src2_reg    <= bus.ds_src2;
            rf_src1_reg <= bus.ds_rf_src1;
            rf_src2_reg <= bus.ds_rf_src2;
            dest_reg    <= bus.ds_dest;
            gr_we_reg   <= bus.ds_gr_we;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.es_allowin      = es_allowin;

    assign bus.alu_op          = op_reg;
    assign bus.alu_src1        = src1_reg;
    assign bus.alu_src2        = src2_reg;
    assign bus.alu_rf_src1     = rf_src1_reg;
    assign bus.alu_rf_src2     = rf_src2_reg;
    assign bus.alu_pc          = pc_reg;

    assign bus.es_to_ms_valid  = es_valid & ready_go;
    assign bus.es_to_ms_pc     = pc_reg;
    assign bus.es_to_ms_result = bus.alu_result;
    assign bus.es_to_ms_dest   = dest_reg;
    assign bus.es_to_ms_gr_we  = gr_we_reg;

    assign bus.es_fwd_valid    = es_valid & gr_we_reg & (dest_reg != 5'd0);
    assign bus.es_fwd_dest     = dest_reg;
    assign bus.es_fwd_ready    = ready_go;

    assign bus.br_redirect     = br_redirect;
    assign bus.br_target       = bus.alu_br_target;

endmodule

// File: tb/tb_exe_stage_ctrl.sv
// ----------------------------------------------------------------------------
// tb_exe_stage_ctrl
// Three controller instances (ALU_LAT = 1, 3, 4), each with its own interface,
// behavioural ALU, stimulus process and scoreboard/monitor. The scoreboard
// models the stage as "one instruction in flight whose result becomes visible
// ALU_LAT-1 cycles after the load"; the monitor compares every cycle.
// ----------------------------------------------------------------------------
module tb_exe_stage_ctrl;

    typedef struct packed {
        logic [31:0] result;
        logic        taken;
        logic [31:0] target;
    } alu_out_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  op;
        logic [31:0] s1;
        logic [31:0] s2;
        logic [31:0] r1;
        logic [31:0] r2;
        logic [4:0]  dest;
        logic        we;
    } ds_t;

    typedef struct {
        logic [31:0] pc;
        logic [4:0]  op;
        logic [31:0] result;
        logic        taken;
        logic [31:0] target;
        logic [4:0]  dest;
        logic        we;
        int          ready_cyc;
        bit          redirected;
    } exp_t;

    logic clk;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural ALU, LoongArch-flavoured opcode map.
    function automatic alu_out_t alu_model(input logic [4:0] op, input logic [31:0] s1,
                                           input logic [31:0] s2, input logic [31:0] r1,
                                           input logic [31:0] r2, input logic [31:0] pc);
        alu_out_t o;
        o.result = 32'd0;
        o.taken  = 1'b0;
        o.target = 32'd0;
        case (op)
            5'd0:  o.result = s1 + s2;
            5'd1:  o.result = s1 - s2;
            5'd2:  o.result = {31'd0, $signed(s1) < $signed(s2)};
            5'd3:  o.result = {31'd0, s1 < s2};
            5'd4:  o.result = s1 & s2;
            5'd5:  o.result = ~(s1 | s2);
            5'd6:  o.result = s1 | s2;
            5'd7:  o.result = s1 ^ s2;
            5'd8:  o.result = s1 << s2[4:0];
            5'd9:  o.result = s1 >> s2[4:0];
            5'd10: o.result = $unsigned($signed(s1) >>> s2[4:0]);
            5'd11: begin o.taken = (r1 == r2); o.target = pc + s2; end
            5'd12: begin o.taken = (r1 != r2); o.target = pc + s2; end
            5'd13: begin o.result = pc + 32'd4; o.taken = 1'b1; o.target = pc + s2; end
            5'd14: begin o.result = pc + 32'd4; o.taken = 1'b1; o.target = s1 + s2; end
            5'd15: o.result = s2;
            default: o.result = 32'd0;
        endcase
        return o;
    endfunction

    function automatic void chk(input int lat, input string name,
                                input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL lat%0d %s: got 0x%08h expected 0x%08h (cycle %0d)",
                     lat, name, act, exp, cyc);
        end
    endfunction

    for (genvar gi = 0; gi < 3; gi++) begin : g_lane
        localparam int LAT = (gi == 0) ? 1 : ((gi == 1) ? 3 : 4);

        logic     resetn_l;
        logic     ds_v;
        logic     ms_al;
        ds_t      ds;
        bit       done = 1'b0;
        exp_t     q[$];
        exp_t     item;
        alu_out_t ao;
        bit       exp_valid, exp_redir, exp_allowin, exp_fwd;

        exe_stage_ctrl_if bus ();

        exe_stage_ctrl #(.ALU_LAT(LAT)) dut (
            .clk    (clk),
            .resetn (resetn_l),
            .bus    (bus)
        );

        assign bus.ds_to_es_valid = ds_v;
        assign bus.ms_allowin     = ms_al;
        assign bus.ds_pc          = ds.pc;
        assign bus.ds_alu_op      = ds.op;
        assign bus.ds_src1        = ds.s1;
        assign bus.ds_src2        = ds.s2;
        assign bus.ds_rf_src1     = ds.r1;
        assign bus.ds_rf_src2     = ds.r2;
        assign bus.ds_dest        = ds.dest;
        assign bus.ds_gr_we       = ds.we;

        assign ao = alu_model(bus.alu_op, bus.alu_src1, bus.alu_src2,
                              bus.alu_rf_src1, bus.alu_rf_src2, bus.alu_pc);
        assign bus.alu_result    = ao.result;
        assign bus.alu_br_taken  = ao.taken;
        assign bus.alu_br_target = ao.target;

        // Scoreboard / monitor: compare at negedge, then advance the model
        // for the coming rising edge.
        always @(negedge clk) begin
            if (!resetn_l) begin
                q.delete();
            end else begin
                exp_valid   = (q.size() > 0) && (cyc >= q[0].ready_cyc);
                exp_redir   = exp_valid && q[0].taken && !q[0].redirected;
                exp_allowin = (q.size() == 0) || (exp_valid && ms_al);
                exp_fwd     = (q.size() > 0) && q[0].we && (q[0].dest != 5'd0);

                chk(LAT, "es_to_ms_valid", 32'(bus.es_to_ms_valid), 32'(exp_valid));
                chk(LAT, "es_allowin",     32'(bus.es_allowin),     32'(exp_allowin));
                chk(LAT, "br_redirect",    32'(bus.br_redirect),    32'(exp_redir));
                chk(LAT, "es_fwd_valid",   32'(bus.es_fwd_valid),   32'(exp_fwd));
                chk(LAT, "es_fwd_ready",   32'(bus.es_fwd_ready),   32'(exp_valid));
                if (q.size() > 0) begin
                    chk(LAT, "alu_pc", bus.alu_pc, q[0].pc);
                    chk(LAT, "alu_op", 32'(bus.alu_op), 32'(q[0].op));
                end
                if (exp_valid) begin
                    chk(LAT, "es_to_ms_pc",     bus.es_to_ms_pc,     q[0].pc);
                    chk(LAT, "es_to_ms_result", bus.es_to_ms_result, q[0].result);
                    chk(LAT, "es_to_ms_dest",   32'(bus.es_to_ms_dest),  32'(q[0].dest));
                    chk(LAT, "es_to_ms_gr_we",  32'(bus.es_to_ms_gr_we), 32'(q[0].we));
                end
                if (exp_redir) chk(LAT, "br_target", bus.br_target, q[0].target);
                if (exp_fwd)   chk(LAT, "es_fwd_dest", 32'(bus.es_fwd_dest), 32'(q[0].dest));

                if (exp_redir) q[0].redirected = 1'b1;
                if (exp_valid && ms_al) void'(q.pop_front());
                if (ds_v && exp_allowin && !exp_redir) begin
                    alu_out_t e;
                    e = alu_model(ds.op, ds.s1, ds.s2, ds.r1, ds.r2, ds.pc);
                    item.pc         = ds.pc;
                    item.op         = ds.op;
                    item.result     = e.result;
                    item.taken      = e.taken;
                    item.target     = e.target;
                    item.dest       = ds.dest;
                    item.we         = ds.we;
                    item.ready_cyc  = cyc + LAT;
                    item.redirected = 1'b0;
                    q.push_back(item);
                    $display("lat%0d load cycle %0d pc=0x%08h op=%0d result=0x%08h taken=%0b",
                             LAT, cyc + 1, ds.pc, ds.op, e.result, e.taken);
                end
            end
        end

        // Stimulus
        initial begin
            resetn_l = 1'b0;
            ds_v     = 1'b0;
            ms_al    = 1'b1;
            ds       = '0;
            repeat (2) @(posedge clk);
            #1;
            chk(LAT, "rst es_allowin",     32'(bus.es_allowin),     32'd1);
            chk(LAT, "rst es_to_ms_valid", 32'(bus.es_to_ms_valid), 32'd0);
            chk(LAT, "rst br_redirect",    32'(bus.br_redirect),    32'd0);
            chk(LAT, "rst es_fwd_valid",   32'(bus.es_fwd_valid),   32'd0);
            chk(LAT, "rst alu_op",         32'(bus.alu_op),         32'd0);
            chk(LAT, "rst alu_src1",       bus.alu_src1,            32'd0);
            chk(LAT, "rst alu_src2",       bus.alu_src2,            32'd0);
            chk(LAT, "rst alu_rf_src1",    bus.alu_rf_src1,         32'd0);
            chk(LAT, "rst alu_rf_src2",    bus.alu_rf_src2,         32'd0);
            chk(LAT, "rst alu_pc",         bus.alu_pc,              32'd0);
            resetn_l = 1'b1;
            @(posedge clk); #1;

            // Back-to-back adds, first one 5+7.
            for (int k = 0; k < 4; k++) begin
                ds   = '{pc: 32'h1c000100 + 32'(4*k), op: 5'd0, s1: 32'd5 + 32'(k),
                         s2: 32'd7, r1: 32'd0, r2: 32'd0, dest: 5'd3, we: 1'b1};
                ds_v = 1'b1;
                repeat (LAT) @(posedge clk);
                #1;
            end
            ds_v = 1'b0;
            repeat (LAT + 2) @(posedge clk);
            #1;

            // Taken beq while MEM stalls: one redirect, result held.
            ms_al = 1'b0;
            ds    = '{pc: 32'h1c000000, op: 5'd11, s1: 32'd0, s2: 32'h10,
                      r1: 32'd9, r2: 32'd9, dest: 5'd0, we: 1'b0};
            ds_v  = 1'b1;
            @(posedge clk); #1;
            ds_v  = 1'b0;
            repeat (LAT + 2) @(posedge clk);
            #1;
            ms_al = 1'b1;
            repeat (3) @(posedge clk);
            #1;

            // Taken beq with decode offering continuously: redirect-cycle offer dropped.
            ds   = '{pc: 32'h1c000200, op: 5'd11, s1: 32'd0, s2: 32'h40,
                     r1: 32'd1, r2: 32'd1, dest: 5'd0, we: 1'b0};
            ds_v = 1'b1;
            @(posedge clk); #1;
            ds   = '{pc: 32'h1c000204, op: 5'd0, s1: 32'd1, s2: 32'd2,
                     r1: 32'd0, r2: 32'd0, dest: 5'd4, we: 1'b1};
            repeat (LAT + 3) @(posedge clk);
            #1;
            ds_v = 1'b0;
            repeat (LAT + 2) @(posedge clk);
            #1;

            // bne not taken: no redirect, result still delivered.
            ds   = '{pc: 32'h1c000300, op: 5'd12, s1: 32'd0, s2: 32'h20,
                     r1: 32'd6, r2: 32'd6, dest: 5'd0, we: 1'b0};
            ds_v = 1'b1;
            @(posedge clk); #1;
            ds_v = 1'b0;
            repeat (LAT + 2) @(posedge clk);
            #1;

            // Random traffic.
            for (int k = 0; k < 400; k++) begin
                ds.pc   = 32'h1c000000 + {$urandom_range(0, 4095), 2'b00};
                ds.op   = 5'($urandom_range(0, 15));
                ds.s1   = $urandom;
                ds.s2   = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 255));
                ds.r1   = 32'($urandom_range(0, 3));
                ds.r2   = 32'($urandom_range(0, 3));
                ds.dest = 5'($urandom_range(0, 31));
                ds.we   = 1'($urandom_range(0, 1));
                ds_v    = ($urandom_range(0, 3) != 0);
                ms_al   = ($urandom_range(0, 3) != 0);
                @(posedge clk); #1;
            end
            ds_v  = 1'b0;
            ms_al = 1'b1;
            repeat (LAT + 2) @(posedge clk);
            #1;

            // Reset while a bl is in flight: discarded at once, never redirects.
            ds   = '{pc: 32'h1c000400, op: 5'd13, s1: 32'd0, s2: 32'h80,
                     r1: 32'd0, r2: 32'd0, dest: 5'd1, we: 1'b1};
            ds_v = 1'b1;
            @(posedge clk); #1;
            ds_v = 1'b0;
            #2 resetn_l = 1'b0;
            #1;
            chk(LAT, "midrst es_to_ms_valid", 32'(bus.es_to_ms_valid), 32'd0);
            chk(LAT, "midrst es_allowin",     32'(bus.es_allowin),     32'd1);
            chk(LAT, "midrst br_redirect",    32'(bus.br_redirect),    32'd0);
            @(posedge clk); #1;
            resetn_l = 1'b1;
            repeat (LAT + 3) @(posedge clk);
            #1;
            done = 1'b1;
        end
    end

    initial begin
        bit all_done;
        all_done = 1'b0;
        for (int t = 0; t < 5000 && !all_done; t++) begin
            @(posedge clk);
            all_done = g_lane[0].done && g_lane[1].done && g_lane[2].done;
        end
        if (!all_done) begin
            errors++;
            $display("FAIL timeout: lanes not finished, got 0 expected 1");
        end
        #2;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
